// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the fast-monitoring spy-buffer freeze controller.
// Holds the sequencer state encoding, the playback-mode values and the bank size.
package fm_sb_pkg;

  localparam int sb_mapped_n   = 29;
  localparam int pb_mode_width = 2;
  localparam int SB_N_DEFAULT  = sb_mapped_n;

  localparam logic [pb_mode_width-1:0] SB_MODE_CAPTURE = 2'd0;
  localparam logic [pb_mode_width-1:0] SB_MODE_PB_ONCE = 2'd1;
  localparam logic [pb_mode_width-1:0] SB_MODE_PB_LOOP = 2'd2;
  localparam logic [pb_mode_width-1:0] SB_MODE_HALT    = 2'd3;

  typedef enum logic [2:0] {
    SB_IDLE     = 3'd0,
    SB_ARMED    = 3'd1,
    SB_POST     = 3'd2,
    SB_FROZEN   = 3'd3,
    SB_PLAYBACK = 3'd4
  } sb_fsm_t;

endpackage

// File: rtl/fm_sb_post_counter.sv
// Loadable post-trigger down-counter; tc flags the last post-trigger write cycle.
// The counter holds at zero rather than wrapping if decremented past it.
module fm_sb_post_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/fm_sb_freeze_ctrl.sv
// Global arm/freeze/playback sequencer driving the whole spy-buffer bank coherently.
// Outputs are registered from the next state so they move one cycle after their cause.
module fm_sb_freeze_ctrl
  import fm_sb_pkg::*;
#(
  parameter int SB_N      = SB_N_DEFAULT,
  parameter int PB_MODE_W = pb_mode_width,
  parameter int POST_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PB_MODE_W-1:0] mode_i,
  input  logic                 arm_i,
  input  logic                 trig_i,
  input  logic                 sw_trig_i,
  input  logic [POST_W-1:0]    post_cnt_i,
  input  logic [SB_N-1:0]      sb_mask_i,
  input  logic [SB_N-1:0]      pb_done_i,
  output logic [SB_N-1:0]      wr_en_o,
  output logic [SB_N-1:0]      freeze_o,
  output logic [SB_N-1:0]      pb_en_o,
  output logic                 pb_restart_o,
  output logic [2:0]           state_o,
  output logic [POST_W-1:0]    trig_cnt_o
);

  sb_fsm_t         state, nxt;
  logic [SB_N-1:0] done_vec, done_nxt, live_done;
  logic            trig, covered, restart_nxt, cnt_load, cnt_dec, cnt_tc, count_trig;

  fm_sb_post_counter #(.W(POST_W)) u_post_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (post_cnt_i),
    .tc       (cnt_tc)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    trig        = trig_i | sw_trig_i;
    // Done pulses coinciding with a pointer rewind belong to the previous pass.
    live_done   = pb_done_i & sb_mask_i & {SB_N{~pb_restart_o}};
    covered     = ((done_vec | live_done) & sb_mask_i) == sb_mask_i;
    done_nxt    = done_vec | live_done;
    nxt         = state;
    restart_nxt = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    count_trig  = 1'b0;

    case (state)
      SB_IDLE, SB_FROZEN: begin
        if (arm_i) begin
          if (mode_i == SB_MODE_CAPTURE) begin
            nxt = SB_ARMED;
          end else if (mode_i == SB_MODE_PB_ONCE || mode_i == SB_MODE_PB_LOOP) begin
            nxt         = SB_PLAYBACK;
            restart_nxt = 1'b1;
          end
        end
      end
      SB_ARMED: begin
        if (trig) begin
          cnt_load   = 1'b1;
          count_trig = 1'b1;
          nxt        = (post_cnt_i == '0) ? SB_FROZEN : SB_POST;
        end
      end
      SB_POST: begin
        cnt_dec = 1'b1;
        if (cnt_tc) nxt = SB_FROZEN;
      end
      SB_PLAYBACK: begin
        if (covered) begin
          if (mode_i == SB_MODE_PB_LOOP) restart_nxt = 1'b1;
          else                           nxt = SB_FROZEN;
        end
      end
      default: nxt = SB_IDLE;
    endcase

    // Halt is an abort and wins over every other transition.
    if (mode_i == SB_MODE_HALT) begin
      nxt         = SB_IDLE;
      restart_nxt = 1'b0;
      cnt_load    = 1'b0;
      count_trig  = 1'b0;
    end

    if (nxt != SB_PLAYBACK || restart_nxt) done_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SB_IDLE;
      done_vec     <= '0;
      wr_en_o      <= '0;
      freeze_o     <= '0;
      pb_en_o      <= '0;
      pb_restart_o <= 1'b0;
      trig_cnt_o   <= '0;
    end else begin
      state        <= nxt;
      done_vec     <= done_nxt;
      pb_restart_o <= restart_nxt;
      wr_en_o      <= (nxt == SB_ARMED || nxt == SB_POST) ? sb_mask_i : '0;
      freeze_o     <= (nxt inside {SB_IDLE, SB_FROZEN, SB_PLAYBACK}) ? sb_mask_i : '0;
      pb_en_o      <= (nxt == SB_PLAYBACK) ? sb_mask_i : '0;
      if (count_trig && trig_cnt_o != {POST_W{1'b1}}) trig_cnt_o <= trig_cnt_o + 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fm_sb_freeze_ctrl.sv
// Scoreboard bench for fm_sb_freeze_ctrl: stimulus queues full expected output snapshots
// tagged with a cycle number, and a negedge monitor compares them against the DUT.
module tb_fm_sb_freeze_ctrl;

  localparam int SBN = 29;
  localparam int PW  = 4;
  localparam logic [SBN-1:0] ALL  = {SBN{1'b1}};
  localparam logic [SBN-1:0] NONE = '0;
  localparam logic [SBN-1:0] M5   = 29'h5;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_POST = 3'd2,
                         S_FROZEN = 3'd3, S_PB = 3'd4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     mode;
  logic           arm, trig, sw_trig;
  logic [PW-1:0]  post_cnt;
  logic [SBN-1:0] mask, pb_done;
  logic [SBN-1:0] wr_en, freeze, pb_en;
  logic           pb_restart;
  logic [2:0]     state;
  logic [PW-1:0]  trig_cnt;

  fm_sb_freeze_ctrl #(.SB_N(SBN), .PB_MODE_W(2), .POST_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode),
    .arm_i        (arm),
    .trig_i       (trig),
    .sw_trig_i    (sw_trig),
    .post_cnt_i   (post_cnt),
    .sb_mask_i    (mask),
    .pb_done_i    (pb_done),
    .wr_en_o      (wr_en),
    .freeze_o     (freeze),
    .pb_en_o      (pb_en),
    .pb_restart_o (pb_restart),
    .state_o      (state),
    .trig_cnt_o   (trig_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             at;
    string          name;
    logic [2:0]     st;
    logic [SBN-1:0] wr;
    logic [SBN-1:0] frz;
    logic [SBN-1:0] pb;
    logic           rs;
    logic [PW-1:0]  tc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp_at(input int at, input string nm, input logic [2:0] st,
                        input logic [SBN-1:0] wr, input logic [SBN-1:0] frz,
                        input logic [SBN-1:0] pb, input logic rs, input logic [PW-1:0] tc);
    exp_t e;
    e.at = at; e.name = nm; e.st = st; e.wr = wr; e.frz = frz; e.pb = pb; e.rs = rs; e.tc = tc;
    sbq.push_back(e);
  endtask

  // Monitor: compares every queued snapshot due this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at <= cyc) begin
        checks++;
        if (sbq[i].at < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                   sbq[i].name, sbq[i].at, cyc);
        end else if (state !== sbq[i].st || wr_en !== sbq[i].wr || freeze !== sbq[i].frz ||
                     pb_en !== sbq[i].pb || pb_restart !== sbq[i].rs || trig_cnt !== sbq[i].tc) begin
          errors++;
          $display("FAIL %s @%0d: got st=%0d wr=%h frz=%h pb=%h rs=%b tc=%0d exp st=%0d wr=%h frz=%h pb=%h rs=%b tc=%0d",
                   sbq[i].name, cyc, state, wr_en, freeze, pb_en, pb_restart, trig_cnt,
                   sbq[i].st, sbq[i].wr, sbq[i].frz, sbq[i].pb, sbq[i].rs, sbq[i].tc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p, r, c;
    logic [PW-1:0] exp_tc;

    rst = 1'b1; mode = 2'd0; arm = 1'b0; trig = 1'b0; sw_trig = 1'b0;
    post_cnt = '0; mask = ALL; pb_done = '0;
    step(); step();

    // Reset state, then freeze follows the mask one cycle after release.
    exp_at(cyc, "reset", S_IDLE, NONE, NONE, NONE, 1'b0, 4'd0);
    rst = 1'b0;
    exp_at(cyc + 1, "idle_after_rst", S_IDLE, NONE, ALL, NONE, 1'b0, 4'd0);
    step();

    // Capture with post_cnt=8; a trigger inside POST must be ignored.
    arm = 1'b1;
    exp_at(cyc + 1, "arm_capture", S_ARMED, ALL, NONE, NONE, 1'b0, 4'd0);
    step();
    arm = 1'b0; trig = 1'b1; post_cnt = 4'd8; t = cyc;
    for (int k = 1; k <= 8; k++) exp_at(t + k, "post_write", S_POST, ALL, NONE, NONE, 1'b0, 4'd1);
    exp_at(t + 9, "capture_frozen", S_FROZEN, NONE, ALL, NONE, 1'b0, 4'd1);
    step();
    trig = 1'b0;
    run_to(t + 3);
    trig = 1'b1;
    step();
    trig = 1'b0;
    run_to(t + 10);

    // Zero post count via software trigger.
    arm = 1'b1;
    exp_at(cyc + 1, "rearm", S_ARMED, ALL, NONE, NONE, 1'b0, 4'd1);
    step();
    arm = 1'b0; sw_trig = 1'b1; post_cnt = 4'd0; t = cyc;
    exp_at(t + 1, "zero_post", S_FROZEN, NONE, ALL, NONE, 1'b0, 4'd2);
    exp_at(t + 2, "zero_post_hold", S_FROZEN, NONE, ALL, NONE, 1'b0, 4'd2);
    step();
    sw_trig = 1'b0;
    step();

    // Playback once on SB0/SB2 with sticky done tracking.
    mask = M5; mode = 2'd1; arm = 1'b1; p = cyc;
    exp_at(p + 1, "pb_once_start", S_PB, NONE, M5, M5, 1'b1, 4'd2);
    step();
    arm = 1'b0; pb_done = ALL;
    exp_at(p + 2, "pb_done_in_restart", S_PB, NONE, M5, M5, 1'b0, 4'd2);
    step();
    pb_done = 29'h2;
    exp_at(p + 3, "pb_done_masked", S_PB, NONE, M5, M5, 1'b0, 4'd2);
    step();
    pb_done = 29'h1;
    exp_at(p + 4, "pb_done0", S_PB, NONE, M5, M5, 1'b0, 4'd2);
    step();
    pb_done = '0;
    exp_at(p + 5, "pb_gap", S_PB, NONE, M5, M5, 1'b0, 4'd2);
    step();
    pb_done = 29'h4;
    exp_at(p + 6, "pb_once_done", S_FROZEN, NONE, M5, NONE, 1'b0, 4'd2);
    step();
    pb_done = '0;
    step();

    // Playback loop across all buffers, three restarts.
    mask = ALL; mode = 2'd2; arm = 1'b1; r = cyc + 1;
    exp_at(r, "pb_loop_start", S_PB, NONE, ALL, ALL, 1'b1, 4'd2);
    step();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pb_done = ALL;
      exp_at(r + 1, "loop_ignore_on_restart", S_PB, NONE, ALL, ALL, 1'b0, 4'd2);
      step();
      exp_at(r + 2, "loop_restart", S_PB, NONE, ALL, ALL, 1'b1, 4'd2);
      step();
      r = r + 2;
    end

    // Reset in the middle of playback.
    pb_done = '0; rst = 1'b1; mode = 2'd0;
    exp_at(r + 1, "rst_in_pb", S_IDLE, NONE, NONE, NONE, 1'b0, 4'd0);
    step();
    rst = 1'b0;
    exp_at(r + 2, "post_rst_idle", S_IDLE, NONE, ALL, NONE, 1'b0, 4'd0);
    step();

    // Abort from POST, then halt mode ignores arm.
    arm = 1'b1;
    exp_at(cyc + 1, "abort_arm", S_ARMED, ALL, NONE, NONE, 1'b0, 4'd0);
    step();
    arm = 1'b0; trig = 1'b1; post_cnt = 4'd8; t = cyc;
    exp_at(t + 1, "abort_post1", S_POST, ALL, NONE, NONE, 1'b0, 4'd1);
    exp_at(t + 2, "abort_post2", S_POST, ALL, NONE, NONE, 1'b0, 4'd1);
    step();
    trig = 1'b0;
    step();
    mode = 2'd3;
    exp_at(t + 3, "abort", S_IDLE, NONE, ALL, NONE, 1'b0, 4'd1);
    step();
    arm = 1'b1;
    exp_at(t + 4, "halt_ignores_arm", S_IDLE, NONE, ALL, NONE, 1'b0, 4'd1);
    step();
    arm = 1'b0; mode = 2'd0;

    // Saturation: 20 arm/trigger rounds; arm cycle carries a dropped trigger,
    // and early rounds fire both triggers together as a single event.
    exp_tc = 4'd1; post_cnt = 4'd0;
    for (int i = 0; i < 20; i++) begin
      arm = 1'b1; trig = 1'b1; c = cyc;
      exp_at(c + 1, "sat_arm", S_ARMED, ALL, NONE, NONE, 1'b0, exp_tc);
      step();
      arm = 1'b0; trig = 1'b1; sw_trig = (i < 3);
      exp_tc = (exp_tc == 4'd15) ? 4'd15 : exp_tc + 4'd1;
      exp_at(c + 2, "sat_trig", S_FROZEN, NONE, ALL, NONE, 1'b0, exp_tc);
      step();
      trig = 1'b0; sw_trig = 1'b0;
    end
    exp_at(cyc + 2, "sat_final", S_FROZEN, NONE, ALL, NONE, 1'b0, 4'd15);
    step(); step(); step();

    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sbq[0].name, sbq[0].at);
      void'(sbq.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_sb_freeze_ctrl.md
# fm_sb_freeze_ctrl

Global capture/freeze/playback sequencer for the fast-monitoring spy buffers. It sits between the FM control registers and the bank of `sb_mapped_n` spy buffers (27 L0MDT plus 2 dummy). It arms all unmasked buffers together and freezes them a programmable number of cycles after a trigger. It then optionally sequences playback, so that software reads a coherent snapshot across every station and thread.

## Interface
Parameters:
- SB_N, 29, number of spy buffers (equals `sb_mapped_n`)
- PB_MODE_W, 2, playback-mode field width (equals `pb_mode_width`)
- POST_W, 16, width of the post-trigger counter

Ports:
- clk  in  1  fabric clock; the only clock
- rst  in  1  synchronous, active-high reset
- mode_i  in  PB_MODE_W  operating mode: 0 = capture, 1 = playback once, 2 = playback loop, 3 = halt
- arm_i  in  1  single-cycle arm request from the register bank
- trig_i  in  1  hardware trigger pulse
- sw_trig_i  in  1  software trigger pulse
- post_cnt_i  in  POST_W  number of cycles to keep writing after a trigger
- sb_mask_i  in  SB_N  1 = buffer participates
- pb_done_i  in  SB_N  per-buffer "last playback word issued" pulse
- wr_en_o  out  SB_N  capture write enable per buffer
- freeze_o  out  SB_N  per-buffer freeze
- pb_en_o  out  SB_N  per-buffer playback enable
- pb_restart_o  out  1  single-cycle pulse that rewinds playback pointers
- state_o  out  3  current FSM state encoding
- trig_cnt_o  out  POST_W  accepted-trigger count; saturating

## Operation
- FSM states: IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAYBACK=4.
- IDLE
  - All outputs are zero except freeze_o, which equals sb_mask_i.
  - On arm_i with mode_i==0, go to ARMED.
  - On arm_i with mode_i∈{1,2}, go to PLAYBACK and assert pb_restart_o for one cycle.
  - mode_i==3 ignores arm_i.
- ARMED
  - wr_en_o = sb_mask_i and freeze_o = 0.
  - The trigger is trig_i | sw_trig_i. On a trigger, load the down-counter with post_cnt_i, increment trig_cnt_o, and go to POST.
  - If post_cnt_i==0, go directly to FROZEN instead.
- POST
  - wr_en_o remains asserted while the counter decrements.
  - At count 1, go to FROZEN the next cycle. This gives exactly post_cnt_i post-trigger writes, counting the trigger cycle as write 0.
  - Further triggers are ignored and not counted.
- FROZEN
  - wr_en_o = 0 and freeze_o = sb_mask_i.
  - arm_i re-enters ARMED or PLAYBACK according to mode_i, as in IDLE.
- PLAYBACK
  - pb_en_o = sb_mask_i and freeze_o = sb_mask_i.
  - Track a sticky done vector. When (done | pb_done_i) covers sb_mask_i:
    - mode 1: go to FROZEN.
    - mode 2: clear the done vector, pulse pb_restart_o, and stay in PLAYBACK.
- mode_i==3 in any state: go to IDLE on the next cycle; this is an abort.
- sb_mask_i is sampled continuously. Masked-off buffers always get wr_en_o=0 and pb_en_o=0, and their pb_done_i is ignored.
- An all-zero mask in PLAYBACK completes immediately on the first cycle.

## Timing
- All outputs are registered and change one cycle after the causing input edge.
- Example: trig_i high at cycle t puts state_o=POST at t+1. The last wr_en_o cycle is t+post_cnt_i, and freeze_o rises at t+post_cnt_i+1.
- Reset values:
  - state_o = IDLE
  - wr_en_o = 0, pb_en_o = 0, pb_restart_o = 0
  - freeze_o = 0; it takes the IDLE value one cycle after reset deasserts
  - trig_cnt_o = 0, down-counter = 0, done vector = 0
- trig_cnt_o saturates at 2^POST_W−1 and clears only on rst.
- Simultaneous events:
  - arm_i and a trigger in the same cycle from IDLE: arm takes effect, the trigger is dropped.
  - trig_i and sw_trig_i in the same cycle count as one trigger.
  - mode_i==3 overrides every other transition.
- rst mid-POST or mid-PLAYBACK: all outputs return to their reset values next cycle; there is no partial freeze.
- pb_done_i arriving in the same cycle as pb_restart_o is ignored.

## Structure
- fm_sb_pkg holds:
  - the state enum `sb_fsm_t`;
  - mode constants SB_MODE_CAPTURE/PB_ONCE/PB_LOOP/HALT;
  - SB_N defaulting to `sb_mapped_n`.
- One sub-module, `fm_sb_post_counter`, implements the loadable down-counter with terminal-count flag.
- The FSM, done-vector tracking and output registers live in the top module.

## Test plan
- Capture: mode 0, mask=all ones, arm, trig_i at t with post_cnt_i=8. Expect wr_en_o high through t+8, freeze_o=all ones at t+9, trig_cnt_o=1.
- Zero post count: post_cnt_i=0 and sw_trig_i at t. Expect FROZEN at t+1 and no wr_en_o cycle after t.
- Playback once: mask=0x5 (SB0, SB2), arm with mode 1. Expect pb_restart_o one cycle high, pb_en_o=0x5. Pulse pb_done_i[0] then pb_done_i[2]; expect FROZEN one cycle after the second pulse. pb_done_i[1] alone has no effect.
- Playback loop: mode 2, all 29 buffers report done in the same cycle. Expect pb_restart_o pulsed and the FSM still in PLAYBACK; repeat three loops.
- Abort and reset: mode_i=3 during POST gives IDLE next cycle. rst during PLAYBACK zeroes all outputs; trig_cnt_o reads 0 after rst.
- Saturation and ignore: with POST_W=4, issue 20 arm/trigger cycles and expect trig_cnt_o=15. Triggers during POST do not increment the count.
